sphere_contact_collector: RTL and testbench

Downstream of the sphere-pair collision stage: captures each completed contact result (position, normal, depth, geom IDs) on the stage's done strobe, discards non-colliding results, and buffers accepted contacts in a small FIFO. Drains to the contact-joint builder over a valid/ready handshake. Keeps a sticky overflow flag and a dropped-contact counter so software can detect lost contacts.

---
 rtl/contact_pkg.sv | 40 ++++
 rtl/contact_fifo_mem.sv | 27 ++
 rtl/sphere_contact_collector.sv | 138 +++++++++++++
 tb/tb_sphere_contact_collector.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/contact_pkg.sv
// Contact record layout, float field constants and the depth-sign helper shared by the collector.
package contact_pkg;

   localparam int WORD_W = 32;
   localparam int REC_W  = 288;

   localparam int POS_X_LSB = 0;
   localparam int POS_Y_LSB = 32;
   localparam int POS_Z_LSB = 64;
   localparam int NRM_X_LSB = 96;
   localparam int NRM_Y_LSB = 128;
   localparam int NRM_Z_LSB = 160;
   localparam int DEPTH_LSB = 192;
   localparam int G1_LSB    = 224;
   localparam int G2_LSB    = 256;

   localparam logic [WORD_W-1:0] FP_ZERO     = 32'h0000_0000;
   localparam int                FP_SIGN_BIT = 31;

   // First member lands in the MSBs, so cx sits at [31:0].
   typedef struct packed {
      logic [WORD_W-1:0] g2;
      logic [WORD_W-1:0] g1;
      logic [WORD_W-1:0] depth;
      logic [WORD_W-1:0] nz;
      logic [WORD_W-1:0] ny;
      logic [WORD_W-1:0] nx;
      logic [WORD_W-1:0] cz;
      logic [WORD_W-1:0] cy;
      logic [WORD_W-1:0] cx;
   } contact_rec_t;

   // +0.0 and -0.0 both count as "no penetration".
   function automatic logic depth_is_positive(input logic [WORD_W-1:0] d);
      logic [FP_SIGN_BIT-1:0] mag_zero;
      mag_zero = FP_ZERO[FP_SIGN_BIT-1:0];
      return ~(d[FP_SIGN_BIT] | (d[FP_SIGN_BIT-1:0] == mag_zero));
   endfunction

endpackage

// File: rtl/contact_fifo_mem.sv
// DEPTH x REC_W contact storage: one synchronous write port, one asynchronous read port.
// Storage is intentionally not reset; validity is tracked by the owner's count.
module contact_fifo_mem
   import contact_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             CLK_d,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [REC_W-1:0] wr_dat,
   input  logic [AW-1:0]    rd_addr,
   output logic [REC_W-1:0] rd_dat
);

   logic [REC_W-1:0] mem_q [DEPTH];

   always_ff @(posedge CLK_d) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/sphere_contact_collector.sv
// Captures contacts on done rising (stored 2 edges after rise), FWFT drain on out_valid/out_ready,
// full FIFO drops with sticky overflow + saturating counter. SPHERE_CONTACT_DEPTH_FILTER_EN drops depth<=0.
module sphere_contact_collector
   import contact_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                     CLK_d,
   input  logic                     rst,
   input  logic                     done,
   input  logic                     ret,
   input  logic [WORD_W-1:0]        cx,
   input  logic [WORD_W-1:0]        cy,
   input  logic [WORD_W-1:0]        cz,
   input  logic [WORD_W-1:0]        normalx,
   input  logic [WORD_W-1:0]        normaly,
   input  logic [WORD_W-1:0]        normalz,
   input  logic [WORD_W-1:0]        depth,
   input  logic [WORD_W-1:0]        g1,
   input  logic [WORD_W-1:0]        g2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [REC_W-1:0]         out_rec,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [CNT_W-1:0]         dropped,
   input  logic                     clr_flags
);

   localparam int               AW       = $clog2(DEPTH);
   localparam int               CW       = AW + 1;
   localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

   logic               done_q, done_d;
   logic               arm_q, arm_d;
   logic               cap_vld_q, cap_vld_d;
   contact_rec_t       cap_rec_q, cap_rec_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [CNT_W-1:0]   dropped_q, dropped_d;

   contact_rec_t       in_rec;
   logic               depth_ok;
   logic               capture;
   logic               push;
   logic               pop;
   logic               drop;

   assign in_rec = '{g2: g2, g1: g1, depth: depth,
                     nz: normalz, ny: normaly, nx: normalx,
                     cz: cz, cy: cy, cx: cx};

`ifdef SPHERE_CONTACT_DEPTH_FILTER_EN
   assign depth_ok = depth_is_positive(depth);
`else
   assign depth_ok = 1'b1;
`endif

   // arm_q blocks a false edge when done is already high as reset releases.
   always_comb begin
      done_d    = done;
      arm_d     = arm_q | ~done;
      capture   = done & ~done_q & arm_q;
      cap_vld_d = capture & ret & depth_ok;
      cap_rec_d = capture ? in_rec : cap_rec_q;

      pop  = (count_q != '0) & out_ready;
      push = cap_vld_q & ((count_q != CNT_FULL) | pop);
      drop = cap_vld_q & ~push;

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as clr_flags still registers.
      overflow_d = clr_flags ? 1'b0 : overflow_q;
      dropped_d  = clr_flags ? '0   : dropped_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (dropped_d != '1) begin
            dropped_d = dropped_d + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK_d or negedge rst) begin
      if (!rst) begin
         done_q     <= 1'b0;
         arm_q      <= 1'b0;
         cap_vld_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
      end else begin
         done_q     <= done_d;
         arm_q      <= arm_d;
         cap_vld_q  <= cap_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   always_ff @(posedge CLK_d) begin
      cap_rec_q <= cap_rec_d;
   end

   contact_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .CLK_d   (CLK_d),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_dat  (cap_rec_q),
      .rd_addr (rd_ptr_q),
      .rd_dat  (out_rec)
   );

   assign out_valid = (count_q != '0);
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_sphere_contact_collector.sv
// Directed stimulus for sphere_contact_collector with a queue scoreboard checked on every pop handshake.
module tb_sphere_contact_collector;

   localparam int DEPTH = 8;
   localparam int CNT_W = 8;

   logic          CLK_d = 1'b0;
   logic          rst;
   logic          done, ret;
   logic [31:0]   cx, cy, cz, normalx, normaly, normalz, depth, g1, g2;
   logic          out_valid, out_ready;
   logic [287:0]  out_rec;
   logic [3:0]    count;
   logic          overflow;
   logic [7:0]    dropped;
   logic          clr_flags;

   int checks   = 0;
   int failures = 0;
   logic [287:0] exp_q[$];

   sphere_contact_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK_d(CLK_d), .rst(rst), .done(done), .ret(ret),
      .cx(cx), .cy(cy), .cz(cz),
      .normalx(normalx), .normaly(normaly), .normalz(normalz),
      .depth(depth), .g1(g1), .g2(g2),
      .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
      .count(count), .overflow(overflow), .dropped(dropped),
      .clr_flags(clr_flags)
   );

   always #5 CLK_d = ~CLK_d;

   // Monitor: a handshake visible at negedge completes at the next posedge.
   always @(negedge CLK_d) begin
      if (rst && out_valid && out_ready) begin
         logic [287:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected act=%h", out_rec);
         end else begin
            e = exp_q.pop_front();
            if (out_rec !== e) begin
               failures++;
               $display("FAIL pop_rec act=%h exp=%h", out_rec, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK_d);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic set_data(input logic [31:0] base, input logic [31:0] dv);
      cx      = base;
      cy      = base + 32'h10;
      cz      = base + 32'h20;
      normalx = base + 32'h30;
      normaly = base + 32'h40;
      normalz = base + 32'h50;
      depth   = dv;
      g1      = base + 32'h100;
      g2      = base + 32'h200;
   endtask

   task automatic cap(input logic r, input logic [31:0] base, input logic [31:0] dv,
                      input bit store, input bit pop_at_push);
      set_data(base, dv);
      ret  = r;
      done = 1'b1;
      if (store) exp_q.push_back({g2, g1, depth, normalz, normaly, normalx, cz, cy, cx});
      step();
      done = 1'b0;
      if (pop_at_push) out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      repeat (n) step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0; done = 1'b0; ret = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
      set_data(32'h0, 32'h0);
      repeat (3) step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_dropped", 32'(dropped), 32'd0);
      rst = 1'b1;
      step();

      // Single contact: valid appears two edges after done rise.
      set_data(32'h3F80_0000, 32'h3E00_0000);
      ret = 1'b1; done = 1'b1;
      exp_q.push_back({g2, g1, depth, normalz, normaly, normalx, cz, cy, cx});
      step();
      chk("single_valid_edge1", 32'(out_valid), 32'd0);
      done = 1'b0;
      step();
      chk("single_valid_edge2", 32'(out_valid), 32'd1);
      chk("single_count", 32'(count), 32'd1);
      chk("single_cx", out_rec[31:0], 32'h3F80_0000);
      chk("single_depth", out_rec[223:192], 32'h3E00_0000);
      drain(1);
      chk("single_pop_count", 32'(count), 32'd0);
      chk("single_pop_valid", 32'(out_valid), 32'd0);

      cap(1'b0, 32'h5000_0000, 32'h3F00_0000, 1'b0, 1'b0);
      chk("noret_count", 32'(count), 32'd0);
      chk("noret_overflow", 32'(overflow), 32'd0);

      // Ninth capture into a full FIFO is dropped.
      for (int i = 0; i < 9; i++)
         cap(1'b1, 32'h1000_0000 + 32'(i) * 32'h1000, 32'h3F00_0000, (i < 8), 1'b0);
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_overflow", 32'(overflow), 32'd1);
      chk("ovf_dropped", 32'(dropped), 32'd1);

      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_dropped", 32'(dropped), 32'd0);

      // Full with a pop on the push edge: accepted, no overflow.
      cap(1'b1, 32'h2000_0000, 32'h3F00_0000, 1'b1, 1'b1);
      chk("fullsim_count", 32'(count), 32'd8);
      chk("fullsim_overflow", 32'(overflow), 32'd0);
      chk("fullsim_dropped", 32'(dropped), 32'd0);

      for (int i = 0; i < 260; i++)
         cap(1'b1, 32'h3000_0000, 32'h3F00_0000, 1'b0, 1'b0);
      chk("sat_dropped", 32'(dropped), 32'd255);
      chk("sat_overflow", 32'(overflow), 32'd1);

      // Clear and drop on the same edge: the drop survives.
      set_data(32'h3100_0000, 32'h3F00_0000);
      ret = 1'b1; done = 1'b1;
      step();
      done = 1'b0; clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("clrdrop_overflow", 32'(overflow), 32'd1);
      chk("clrdrop_dropped", 32'(dropped), 32'd1);

      drain(8);
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef SPHERE_CONTACT_DEPTH_FILTER_EN
      cap(1'b1, 32'h4000_0000, 32'hBF00_0000, 1'b0, 1'b0);
      chk("filt_count", 32'(count), 32'd0);
      chk("filt_dropped", 32'(dropped), 32'd1);
      cap(1'b1, 32'h4100_0000, 32'h0000_0000, 1'b0, 1'b0);
      chk("filt_zero_count", 32'(count), 32'd0);
`else
      cap(1'b1, 32'h4000_0000, 32'hBF00_0000, 1'b1, 1'b0);
      chk("nofilt_count", 32'(count), 32'd1);
      chk("nofilt_dropped", 32'(dropped), 32'd1);
      drain(1);
`endif

      // Reset mid-drain, with done held high across release.
      for (int i = 0; i < 8; i++)
         cap(1'b1, 32'h6000_0000 + 32'(i) * 32'h1000, 32'h3F00_0000, 1'b1, 1'b0);
      drain(3);
      chk("mid_count", 32'(count), 32'd5);
      set_data(32'h7000_0000, 32'h3F00_0000);
      ret = 1'b1; done = 1'b1; rst = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_overflow", 32'(overflow), 32'd0);
      chk("mid_rst_dropped", 32'(dropped), 32'd0);
      step();
      rst = 1'b1;
      repeat (3) step();
      chk("held_done_count", 32'(count), 32'd0);
      chk("held_done_valid", 32'(out_valid), 32'd0);
      done = 1'b0;
      step();
      cap(1'b1, 32'h7100_0000, 32'h3F00_0000, 1'b1, 1'b0);
      chk("fresh_count", 32'(count), 32'd1);
      drain(1);
      chk("final_count", 32'(count), 32'd0);
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
